// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate divider, h/v counters, sync/blank flags and a per-frame tick.
// Sync/video_on/frame_tick are registered from next-state counters so they align with pix_x/pix_y.
module vga_timing_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int SYNC_POL  = 0
) (
  input  logic       clk,
  input  logic       reset,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       p_tick,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       frame_tick
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] V_VIS_LAST = 10'(V_DISPLAY - 1);
  localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam logic       ACT      = (SYNC_POL != 0);

  logic [3:0] div_cnt;
  logic [3:0] div_nxt;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic [9:0] h_nxt;
  logic [9:0] v_nxt;

  // Gated by reset so the enable reads 0 while held in reset even when CLK_DIV = 1.
  assign p_tick = (div_cnt == DIV_LAST) && !reset;
  assign pix_x  = h_cnt;
  assign pix_y  = v_cnt;

  always_comb begin
    div_nxt = (div_cnt == DIV_LAST) ? 4'd0 : div_cnt + 4'd1;
    h_nxt   = h_cnt;
    v_nxt   = v_cnt;
    if (p_tick) begin
      if (h_cnt == H_LAST) begin
        h_nxt = 10'd0;
        v_nxt = (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
      end else begin
        h_nxt = h_cnt + 10'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt    <= 4'd0;
      h_cnt      <= 10'd0;
      v_cnt      <= 10'd0;
      hsync      <= ~ACT;
      vsync      <= ~ACT;
      video_on   <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      div_cnt    <= div_nxt;
      h_cnt      <= h_nxt;
      v_cnt      <= v_nxt;
      hsync      <= (h_nxt >= HS_START && h_nxt <= HS_END) ? ACT : ~ACT;
      vsync      <= (v_nxt >= VS_START && v_nxt <= VS_END) ? ACT : ~ACT;
      video_on   <= (h_nxt < H_VIS) && (v_nxt < V_VIS);
      // Pulses on the step from the last visible line into the first blanked one.
      frame_tick <= p_tick && (h_cnt == H_LAST) && (v_cnt == V_VIS_LAST);
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Two shrunken-raster instances (divided/active-low and undivided/active-high) checked every clock
// against an arithmetic model of elapsed clocks since the last reset edge.
module tb_vga_timing_gen;

  localparam int HD = 16, HF = 2, HS = 3, HB = 3;
  localparam int VD = 10, VF = 2, VS = 2, VB = 2;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam int DA = 3;
  localparam int DB = 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       a_hsync, a_vsync, a_video_on, a_p_tick, a_frame_tick;
  logic [9:0] a_pix_x, a_pix_y;
  logic       b_hsync, b_vsync, b_video_on, b_p_tick, b_frame_tick;
  logic [9:0] b_pix_x, b_pix_y;

  vga_timing_gen #(
    .CLK_DIV(DA), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_POL(0)
  ) dut_a (
    .clk(clk), .reset(reset), .hsync(a_hsync), .vsync(a_vsync), .video_on(a_video_on),
    .p_tick(a_p_tick), .pix_x(a_pix_x), .pix_y(a_pix_y), .frame_tick(a_frame_tick)
  );

  vga_timing_gen #(
    .CLK_DIV(DB), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_POL(1)
  ) dut_b (
    .clk(clk), .reset(reset), .hsync(b_hsync), .vsync(b_vsync), .video_on(b_video_on),
    .p_tick(b_p_tick), .pix_x(b_pix_x), .pix_y(b_pix_y), .frame_tick(b_frame_tick)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int k = 0;
  bit k_valid = 1'b0;
  int ft_seen = 0;
  int ft_exp = 0;

  task automatic chk(input string tag, input logic [24:0] got, input logic [24:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at t=%0t k=%0d: got %h expected %h", tag, $time, k, got, exp);
    end
  endtask

  // Packing: {hsync, vsync, video_on, p_tick, frame_tick, pix_x, pix_y}.
  function automatic logic [24:0] model(input int kk, input int d, input bit pol, input bit rst);
    int  p, x, y;
    bit  hs, vs, vo, pt, ft;
    p  = kk / d;
    x  = p % HT;
    y  = (p / HT) % VT;
    pt = !rst && (kk % d == d - 1);
    ft = (kk > 0) && (kk % d == 0) && (x == 0) && (y == VD);
    hs = (x >= HD + HF && x < HD + HF + HS) ? pol : !pol;
    vs = (y >= VD + VF && y < VD + VF + VS) ? pol : !pol;
    vo = (x < HD) && (y < VD);
    return {hs, vs, vo, pt, ft, 10'(x), 10'(y)};
  endfunction

  // k counts clock edges since the most recent edge that sampled reset high.
  always @(posedge clk) begin
    if (reset) begin
      k       <= 0;
      k_valid <= 1'b1;
    end else begin
      k <= k + 1;
    end
  end

  always @(negedge clk) begin
    logic [24:0] ea;
    if (k_valid) begin
      ea = model(k, DA, 1'b0, reset);
      chk("dut_a", {a_hsync, a_vsync, a_video_on, a_p_tick, a_frame_tick, a_pix_x, a_pix_y}, ea);
      chk("dut_b", {b_hsync, b_vsync, b_video_on, b_p_tick, b_frame_tick, b_pix_x, b_pix_y},
          model(k, DB, 1'b1, reset));
      if (a_frame_tick) ft_seen++;
      if (ea[20]) ft_exp++;
    end
  end

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Three full frames of the divided instance: exactly three frame ticks.
    repeat (3 * HT * VT * DA + 10) @(posedge clk);
    #1;
    chk("ft_count3", 25'(ft_seen), 25'd3);
    chk("ft_model", 25'(ft_seen), 25'(ft_exp));

    // Reset landing on the first vsync line of the divided instance.
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat ((VD + VF) * HT * DA + 2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;

    // Randomized run lengths and reset pulse widths.
    for (int i = 0; i < 25; i++) begin
      repeat ($urandom_range(900, 1)) @(posedge clk);
      #1 reset = 1'b1;
      repeat ($urandom_range(3, 1)) @(posedge clk);
      #1 reset = 1'b0;
    end
    repeat (2 * HT * VT * DA) @(posedge clk);
    #1;
    chk("ft_total", 25'(ft_seen), 25'(ft_exp));

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
